// File: rtl/oam_line_scan.sv
// oam_line_scan: walks all OAM entries once per scanline and collects up to
//   MAX_SPR sprites whose Y range covers the line into a small lookup list.
// Latency: start sampled in cycle 0, done pulses in cycle 2*OAM_ENTRIES+2.
// Backpressure: none; scan timing is fixed, start while busy is ignored.
//
// Ports: clk/rst (sync, active-high); start/ly/tall launch a scan;
//   oam_rd/oam_addr/oam_data form a read port with one cycle of read latency;
//   busy/done/spr_count report status; q_idx -> q_y/q_x/q_oam is a
//   combinational list lookup for the sprite fetcher.
// Build option: define OAM_SCAN_XSORT_EN to keep the list sorted ascending by
//   X (stable). Without it, entries are stored in OAM order.
module oam_line_scan #(
  parameter int MAX_SPR     = 10,
  parameter int OAM_ENTRIES = 40,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       ly,
  input  logic             tall,
  output logic             oam_rd,
  output logic [7:0]       oam_addr,
  input  logic [7:0]       oam_data,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] spr_count,
  input  logic [IDX_W-1:0] q_idx,
  output logic [7:0]       q_y,
  output logic [7:0]       q_x,
  output logic [5:0]       q_oam
);

  localparam logic [IDX_W-1:0] MAX_C = IDX_W'(MAX_SPR);
  localparam logic [6:0]       ENT_N = 7'(OAM_ENTRIES);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t state, state_n;

  // ent: entry whose bytes are being addressed; ph: 0 = Y byte, 1 = X byte.
  // Data lags the address by one cycle, so while ph=0 the X byte of entry
  // ent-1 is on oam_data, and while ph=1 the Y byte of entry ent is.
  logic [6:0] ent;
  logic       ph;
  logic [7:0] ly_q;
  logic       tall_q;
  logic [7:0] y_q;

  logic [7:0] y_mem [MAX_SPR];
  logic [7:0] x_mem [MAX_SPR];
  logic [5:0] o_mem [MAX_SPR];

  logic       x_cap;
  logic       in_range;
  logic       store;
  logic [5:0] cur_oam;
  logic [8:0] line9;
  logic [8:0] y9;
  logic [8:0] h9;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (ent == ENT_N) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    oam_rd   = 1'b0;
    oam_addr = 8'd0;
    case (state)
      SCAN: begin
        busy = 1'b1;
        // The final SCAN cycle only consumes the last X byte; no new read.
        if (ent < ENT_N) begin
          oam_rd   = 1'b1;
          oam_addr = {ent[5:0], 1'b0, ph};
        end
      end
      FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- range test and store decision ----------------
  // 9-bit arithmetic so a line near 255 never wraps into a false hit.
  always_comb begin
    line9    = {1'b0, ly_q} + 9'd16;
    y9       = {1'b0, y_q};
    h9       = tall_q ? 9'd16 : 9'd8;
    in_range = (line9 >= y9) && (line9 < (y9 + h9));
  end

  assign x_cap   = (state == SCAN) && !ph && (ent != 7'd0);
  assign store   = x_cap && in_range && (spr_count < MAX_C);
  assign cur_oam = 6'(ent - 7'd1);

  // ---------------- scan counters and latches ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      spr_count <= '0;
      ent       <= '0;
      ph        <= 1'b0;
    end else if (state == IDLE && start) begin
      spr_count <= '0;
      ent       <= '0;
      ph        <= 1'b0;
      ly_q      <= ly;
      tall_q    <= tall;
    end else if (state == SCAN) begin
      ph <= ~ph;
      if (ph) begin
        ent <= ent + 7'd1;
        y_q <= oam_data;
      end
      if (store) spr_count <= spr_count + IDX_W'(1);
    end
  end

  // ---------------- list storage (not reset) ----------------
`ifdef OAM_SCAN_XSORT_EN
  // Insert after every stored entry with X <= new X, which keeps equal X
  // values in OAM order.
  logic [IDX_W-1:0] ins_pos;

  always_comb begin
    ins_pos = '0;
    for (int j = 0; j < MAX_SPR; j++) begin
      if ((IDX_W'(j) < spr_count) && (x_mem[j] <= oam_data))
        ins_pos = ins_pos + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      for (int j = MAX_SPR - 1; j > 0; j--) begin
        if ((IDX_W'(j) > ins_pos) && (IDX_W'(j) <= spr_count)) begin
          y_mem[j] <= y_mem[j-1];
          x_mem[j] <= x_mem[j-1];
          o_mem[j] <= o_mem[j-1];
        end
      end
      y_mem[ins_pos] <= y_q;
      x_mem[ins_pos] <= oam_data;
      o_mem[ins_pos] <= cur_oam;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (store) begin
      y_mem[spr_count] <= y_q;
      x_mem[spr_count] <= oam_data;
      o_mem[spr_count] <= cur_oam;
    end
  end
`endif

  // ---------------- lookup ----------------
  always_comb begin
    q_y   = 8'd0;
    q_x   = 8'd0;
    q_oam = 6'd0;
    if (q_idx < MAX_C) begin
      q_y   = y_mem[q_idx];
      q_x   = x_mem[q_idx];
      q_oam = o_mem[q_idx];
    end
  end

endmodule

// File: tb/tb_oam_line_scan.sv
// Directed bench for oam_line_scan with a behavioural OAM (one cycle read
// latency). Single-entry range cases are table driven; list overflow, X
// ordering, mid-scan reset and ignored restart are hand-written sequences.
module tb_oam_line_scan;
  localparam int MAX_SPR     = 10;
  localparam int OAM_ENTRIES = 40;
  localparam int IDX_W       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       ly;
  logic             tall;
  logic             oam_rd;
  logic [7:0]       oam_addr;
  logic [7:0]       oam_data = 8'd0;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] spr_count;
  logic [IDX_W-1:0] q_idx;
  logic [7:0]       q_y;
  logic [7:0]       q_x;
  logic [5:0]       q_oam;

  logic [7:0] oam [0:4*OAM_ENTRIES-1];

  int n_chk  = 0;
  int n_fail = 0;

  oam_line_scan #(.MAX_SPR(MAX_SPR), .OAM_ENTRIES(OAM_ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .ly(ly), .tall(tall),
    .oam_rd(oam_rd), .oam_addr(oam_addr), .oam_data(oam_data),
    .busy(busy), .done(done), .spr_count(spr_count),
    .q_idx(q_idx), .q_y(q_y), .q_x(q_x), .q_oam(q_oam)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (oam_rd) oam_data <= oam[oam_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 4*OAM_ENTRIES; i++) oam[i] = 8'd0;
  endtask

  task automatic set_ent(input int e, input logic [7:0] y, input logic [7:0] x);
    oam[4*e]   = y;
    oam[4*e+1] = x;
  endtask

  // Pulses start in cycle 0 and follows the scan for 120 cycles, optionally
  // pulsing start again in cycle restart_at. Records the first done cycle,
  // the number of done pulses and any deviation of oam_rd/oam_addr/busy
  // from the expected fixed schedule.
  task automatic run_scan(input int restart_at, output int done_cyc,
                          output int n_done, output int sched_err);
    int exp_addr;
    done_cyc  = -1;
    n_done    = 0;
    sched_err = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (c == restart_at) start = 1'b1;
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c <= 2*OAM_ENTRIES) begin
        exp_addr = 4*((c-1)/2) + ((c-1)%2);
        if (oam_rd !== 1'b1 || oam_addr !== 8'(exp_addr)) sched_err++;
      end else if (oam_rd !== 1'b0) sched_err++;
      if (busy !== ((c <= 2*OAM_ENTRIES+2) ? 1'b1 : 1'b0)) sched_err++;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] ly;
    logic       tall;
    int         ent;
    logic [7:0] y;
    logic [7:0] x;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int dc, nd, se;
    int exp_oam [4];
    int exp_x   [4];

    vecs[0] = '{8'd0,   1'b0, 3,  8'd16,  8'd40,  1};
    vecs[1] = '{8'd10,  1'b0, 0,  8'd18,  8'd60,  0};
    vecs[2] = '{8'd10,  1'b1, 0,  8'd18,  8'd77,  1};
    vecs[3] = '{8'd0,   1'b0, 39, 8'd9,   8'd0,   1};
    vecs[4] = '{8'd0,   1'b0, 5,  8'd17,  8'd30,  0};
    vecs[5] = '{8'd239, 1'b1, 7,  8'd255, 8'd200, 1};
    vecs[6] = '{8'd250, 1'b0, 1,  8'd2,   8'd90,  0};

    rst = 1'b1; start = 1'b0; ly = 8'd0; tall = 1'b0; q_idx = '0;
    clear_oam();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd", oam_rd, 0);
    chk("reset_addr", oam_addr, 0);
    chk("reset_count", spr_count, 0);

    // ---- single-entry range table ----
    for (int v = 0; v < 7; v++) begin
      clear_oam();
      set_ent(vecs[v].ent, vecs[v].y, vecs[v].x);
      ly = vecs[v].ly; tall = vecs[v].tall;
      run_scan(0, dc, nd, se);
      chk($sformatf("v%0d_done_cycle", v), dc, 2*OAM_ENTRIES+2);
      chk($sformatf("v%0d_schedule_errs", v), se, 0);
      chk($sformatf("v%0d_count", v), spr_count, vecs[v].exp_cnt);
      if (vecs[v].exp_cnt == 1) begin
        q_idx = '0; #1;
        chk($sformatf("v%0d_q_y", v), q_y, vecs[v].y);
        chk($sformatf("v%0d_q_x", v), q_x, vecs[v].x);
        chk($sformatf("v%0d_q_oam", v), q_oam, vecs[v].ent);
      end
    end

    // ---- list overflow: 12 hits, X descending 100..89 ----
    clear_oam();
    for (int e = 0; e < 12; e++) set_ent(e, 8'd16, 8'(100 - e));
    ly = 8'd0; tall = 1'b0;
    run_scan(0, dc, nd, se);
    chk("full_done_cycle", dc, 2*OAM_ENTRIES+2);
    chk("full_count", spr_count, MAX_SPR);
    for (int k = 0; k < MAX_SPR; k++) begin
      q_idx = IDX_W'(k); #1;
`ifdef OAM_SCAN_XSORT_EN
      chk($sformatf("full_q_oam%0d", k), q_oam, 9 - k);
      chk($sformatf("full_q_x%0d", k), q_x, 91 + k);
`else
      chk($sformatf("full_q_oam%0d", k), q_oam, k);
      chk($sformatf("full_q_x%0d", k), q_x, 100 - k);
`endif
    end

    // ---- X ordering with a tie (entries 2 and 5 at X=50) ----
    clear_oam();
    set_ent(1, 8'd16, 8'd60);
    set_ent(2, 8'd16, 8'd50);
    set_ent(5, 8'd16, 8'd50);
    set_ent(7, 8'd16, 8'd10);
`ifdef OAM_SCAN_XSORT_EN
    exp_oam = '{7, 2, 5, 1};
    exp_x   = '{10, 50, 50, 60};
`else
    exp_oam = '{1, 2, 5, 7};
    exp_x   = '{60, 50, 50, 10};
`endif
    run_scan(0, dc, nd, se);
    chk("tie_count", spr_count, 4);
    for (int k = 0; k < 4; k++) begin
      q_idx = IDX_W'(k); #1;
      chk($sformatf("tie_q_oam%0d", k), q_oam, exp_oam[k]);
      chk($sformatf("tie_q_x%0d", k), q_x, exp_x[k]);
    end

    // ---- reset asserted in cycle 30 of a scan ----
    clear_oam();
    set_ent(0, 8'd16, 8'd33);
    ly = 8'd0; tall = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    chk("midrst_pre_count", spr_count, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd", oam_rd, 0);
    chk("midrst_count", spr_count, 0);
    chk("midrst_addr", oam_addr, 0);
    run_scan(0, dc, nd, se);
    chk("midrst_new_done_cycle", dc, 2*OAM_ENTRIES+2);
    chk("midrst_new_count", spr_count, 1);

    // ---- second start in cycle 20 is ignored ----
    run_scan(20, dc, nd, se);
    chk("restart_done_cycle", dc, 2*OAM_ENTRIES+2);
    chk("restart_done_pulses", nd, 1);
    chk("restart_schedule_errs", se, 0);
    q_idx = '0; #1;
    chk("restart_q_x", q_x, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
